// File: rtl/matrix_pkg.sv
// Purpose: shared definitions for the LED matrix scanner (mode encodings, default geometry, index-width helper).
// Latency: none (definitions only).
// Backpressure: none.
package matrix_pkg;

  typedef enum logic [1:0] {
    MODE_STATIC = 2'd0,
    MODE_ANIM   = 2'd1,
    MODE_BLINK  = 2'd2,
    MODE_BLANK  = 2'd3
  } mode_e;

  localparam int DEF_ROWS = 16;
  localparam int DEF_COLS = 16;

  // Bits needed to index 0..n-1, never less than one.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pattern_rom.sv
// Purpose: frame bitmaps; maps (frame, row) to one row of column data.
// Latency: combinational; the caller registers the output.
// Backpressure: none.
// Ports: i_frame = frame index, i_row = row index, o_data = COLS-bit row data (1 = LED on).
// Frames: 0 diagonal, 1 checkerboard, 2 hollow border, 3+ left-justified triangle.
module pattern_rom import matrix_pkg::*; #(
  parameter int ROWS    = DEF_ROWS,
  parameter int COLS    = DEF_COLS,
  parameter int NFRAMES = 4,
  localparam int FW     = idx_w(NFRAMES),
  localparam int RW     = idx_w(ROWS)
) (
  input  logic [FW-1:0]   i_frame,
  input  logic [RW-1:0]   i_row,
  output logic [COLS-1:0] o_data
);

  int w_row;
  int w_frame;

  always_comb begin
    w_row   = int'(i_row);
    w_frame = int'(i_frame);
    o_data  = '0;
    for (int c = 0; c < COLS; c++) begin
      case (w_frame)
        0:       o_data[c] = (c == (w_row % COLS));
        1:       o_data[c] = (((c + w_row) % 2) == 0);
        2:       o_data[c] = (w_row == 0) || (w_row == ROWS - 1) || (c == 0) || (c == COLS - 1);
        default: o_data[c] = (c <= (w_row % COLS));
      endcase
    end
  end

endmodule

// File: rtl/matrix_scan_anim.sv
// Purpose: row-scanned LED matrix driver with static, animated, blinking and blank display modes.
// Latency: col is registered from the ROM addressed by next-cycle row/frame, so it lines up with row_bin.
// Backpressure: none; en=0 freezes all counters and blanks col.
// Ports: clk/rst_n clock and async active-low reset; en scan enable; mode display mode; frame_sel
// frame for static/blink; row_bin/row_oh active row; col row data; frame_idx shown frame; scan_done wrap pulse.
module matrix_scan_anim import matrix_pkg::*; #(
  parameter int ROWS       = DEF_ROWS,
  parameter int COLS       = DEF_COLS,
  parameter int NFRAMES    = 4,
  parameter int SCAN_DIV   = 1000,
  parameter int HOLD_SCANS = 50,
  localparam int RW        = idx_w(ROWS),
  localparam int FW        = idx_w(NFRAMES)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [1:0]      mode,
  input  logic [FW-1:0]   frame_sel,
  output logic [RW-1:0]   row_bin,
  output logic [ROWS-1:0] row_oh,
  output logic [COLS-1:0] col,
  output logic [FW-1:0]   frame_idx,
  output logic            scan_done
);

  localparam int DW = idx_w(SCAN_DIV);
  localparam int HW = idx_w(HOLD_SCANS);

  logic [DW-1:0]   r_div, w_div_nxt;
  logic [RW-1:0]   r_row, w_row_nxt;
  logic [FW-1:0]   r_frame, w_frame_nxt, w_sel;
  logic [HW-1:0]   r_hold, w_hold_nxt, w_hold_base;
  logic            r_blink_on, w_blink_nxt, w_blink_base;
  mode_e           r_mode, w_mode_in;
  logic            r_done;
  logic [COLS-1:0] r_col, w_rom_dat;
  logic            w_row_tick, w_wrap, w_mode_chg, w_show;

  assign w_mode_in  = mode_e'(mode);
  assign w_row_tick = en && (r_div == DW'(SCAN_DIV - 1));
  assign w_wrap     = w_row_tick && (r_row == RW'(ROWS - 1));
  assign w_mode_chg = (w_mode_in != r_mode);
  // Out-of-range frame selections fall back to frame 0.
  assign w_sel      = (int'(frame_sel) < NFRAMES) ? frame_sel : '0;

  always_comb begin
    w_div_nxt = r_div;
    w_row_nxt = r_row;
    if (en) begin
      if (w_row_tick) begin
        w_div_nxt = '0;
        w_row_nxt = w_wrap ? '0 : r_row + RW'(1);
      end else begin
        w_div_nxt = r_div + DW'(1);
      end
    end
  end

  // Frame, hold and blink state only move at a scan wrap, so a frame never changes mid-scan.
  // A mode change restarts the hold count and blink phase; the scan just completed then
  // counts as the first one in the new mode.
  always_comb begin
    w_frame_nxt  = r_frame;
    w_hold_nxt   = r_hold;
    w_blink_nxt  = r_blink_on;
    w_hold_base  = w_mode_chg ? '0 : r_hold;
    w_blink_base = w_mode_chg ? 1'b1 : r_blink_on;
    if (w_wrap) begin
      w_hold_nxt  = w_hold_base;
      w_blink_nxt = w_blink_base;
      case (w_mode_in)
        MODE_ANIM: begin
          if (w_hold_base == HW'(HOLD_SCANS - 1)) begin
            w_hold_nxt  = '0;
            w_frame_nxt = (r_frame == FW'(NFRAMES - 1)) ? '0 : r_frame + FW'(1);
          end else begin
            w_hold_nxt = w_hold_base + HW'(1);
          end
        end
        MODE_BLINK: begin
          w_frame_nxt = w_sel;
          if (w_hold_base == HW'(HOLD_SCANS - 1)) begin
            w_hold_nxt  = '0;
            w_blink_nxt = ~w_blink_base;
          end else begin
            w_hold_nxt = w_hold_base + HW'(1);
          end
        end
        MODE_STATIC: w_frame_nxt = w_sel;
        default: ;
      endcase
    end
  end

  // Addressed with next-cycle row/frame so the registered data lands alongside row_bin.
  pattern_rom #(
    .ROWS    (ROWS),
    .COLS    (COLS),
    .NFRAMES (NFRAMES)
  ) u_rom (
    .i_frame (w_frame_nxt),
    .i_row   (w_row_nxt),
    .o_data  (w_rom_dat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div      <= '0;
      r_row      <= '0;
      r_frame    <= '0;
      r_hold     <= '0;
      r_blink_on <= 1'b1;
      r_mode     <= MODE_STATIC;
      r_done     <= 1'b0;
      r_col      <= '0;
    end else begin
      r_div      <= w_div_nxt;
      r_row      <= w_row_nxt;
      r_frame    <= w_frame_nxt;
      r_hold     <= w_hold_nxt;
      r_blink_on <= w_blink_nxt;
      if (w_wrap) begin
        r_mode <= w_mode_in;
      end
      r_done     <= w_wrap;
      r_col      <= w_rom_dat;
    end
  end

  // Display gating uses the mode latched at the last wrap, so mode effects start on a scan boundary.
  assign w_show    = en && (r_mode != MODE_BLANK) && !((r_mode == MODE_BLINK) && !r_blink_on);
  assign col       = w_show ? r_col : '0;
  assign row_bin   = r_row;
  assign frame_idx = r_frame;
  assign scan_done = r_done && en;

  always_comb begin
    row_oh = '0;
    for (int i = 0; i < ROWS; i++) begin
      row_oh[i] = (r_row == RW'(i));
    end
  end

endmodule

// File: tb/tb_matrix_scan_anim.sv
module tb_matrix_scan_anim;

  localparam int ROWS = 16;
  localparam int COLS = 16;
  localparam int NF   = 4;
  localparam int SD   = 4;
  localparam int HOLD = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            en = 1'b0;
  logic [1:0]      mode = 2'd0;
  logic [1:0]      frame_sel = 2'd0;
  logic [3:0]      row_bin;
  logic [ROWS-1:0] row_oh;
  logic [COLS-1:0] col;
  logic [1:0]      frame_idx;
  logic            scan_done;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: enabled-cycle count since reset plus per-scan display state.
  int m_n     = 0;
  int m_frame = 0;
  int m_mode  = 0;
  int m_k     = 0;
  bit m_blink = 1'b1;
  bit m_done  = 1'b0;
  bit m_colv  = 1'b0;

  matrix_scan_anim #(
    .ROWS(ROWS), .COLS(COLS), .NFRAMES(NF), .SCAN_DIV(SD), .HOLD_SCANS(HOLD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .frame_sel(frame_sel),
    .row_bin(row_bin), .row_oh(row_oh), .col(col), .frame_idx(frame_idx),
    .scan_done(scan_done)
  );

  always #5 clk = ~clk;

  function automatic logic [COLS-1:0] pat(input int f, input int r);
    logic [31:0] w;
    case (f)
      0:       w = 32'd1 << (r % COLS);
      1:       w = ((r % 2) == 0) ? {16{2'b01}} : {16{2'b10}};
      2:       w = (r == 0 || r == ROWS - 1) ? 32'hFFFF_FFFF : (32'd1 | (32'd1 << (COLS - 1)));
      default: w = (32'd2 << (r % COLS)) - 32'd1;
    endcase
    return w[COLS-1:0];
  endfunction

  task automatic model_reset();
    m_n = 0; m_frame = 0; m_mode = 0; m_k = 0;
    m_blink = 1'b1; m_done = 1'b0; m_colv = 1'b0;
  endtask

  task automatic model_update();
    int sel;
    if (!rst_n) begin
      model_reset();
    end else begin
      m_colv = 1'b1;
      m_done = 1'b0;
      if (en) begin
        m_n++;
        if (m_n % (SD * ROWS) == 0) begin
          m_done = 1'b1;
          sel = (int'(frame_sel) < NF) ? int'(frame_sel) : 0;
          if (int'(mode) != m_mode) begin
            m_mode = int'(mode); m_k = 0; m_blink = 1'b1;
          end
          m_k++;
          case (m_mode)
            0: m_frame = sel;
            1: if (m_k == HOLD) begin m_frame = (m_frame + 1) % NF; m_k = 0; end
            2: begin
              m_frame = sel;
              if (m_k == HOLD) begin m_blink = !m_blink; m_k = 0; end
            end
            default: ;
          endcase
        end
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int r;
    bit show;
    logic [COLS-1:0] ec;
    r    = (m_n / SD) % ROWS;
    show = en && m_colv && (m_mode != 3) && !(m_mode == 2 && !m_blink);
    ec   = show ? pat(m_frame, r) : '0;
    chk({tag, ".row_bin"},   32'(row_bin),   r);
    chk({tag, ".row_oh"},    32'(row_oh),    32'd1 << r);
    chk({tag, ".col"},       32'(col),       32'(ec));
    chk({tag, ".frame_idx"}, 32'(frame_idx), m_frame);
    chk({tag, ".scan_done"}, 32'(scan_done), 32'(m_done && en));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_all(tag);
  endtask

  // Called at a falling edge; asserts reset mid-cycle and releases it at the next falling edge.
  task automatic do_reset(input bit e, input int md, input int sl);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst.row_bin",   32'(row_bin),   0);
    chk("rst.row_oh",    32'(row_oh),    1);
    chk("rst.col",       32'(col),       0);
    chk("rst.frame_idx", 32'(frame_idx), 0);
    chk("rst.scan_done", 32'(scan_done), 0);
    check_all("rst");
    en = e; mode = 2'(md); frame_sel = 2'(sl);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_done(input string tag, input int bound, output int cyc);
    cyc = 0;
    do begin
      step(tag);
      cyc++;
    end while (!scan_done && cyc < bound);
    chk({tag, ".seen"}, 32'(scan_done), 1);
  endtask

  typedef struct {
    bit en;
    int mode;
    int sel;
    int cycles;
    int exp_row;
    int exp_frame;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int cyc;

    tbl[0] = '{1, 1, 0,   3,  0, 0};
    tbl[1] = '{1, 1, 0,   1,  1, 0};
    tbl[2] = '{1, 1, 0,  60,  0, 0};
    tbl[3] = '{1, 1, 0,  64,  0, 1};
    tbl[4] = '{1, 1, 0, 128,  0, 2};
    tbl[5] = '{0, 1, 0,  10,  0, 2};
    tbl[6] = '{1, 1, 0,  20,  5, 2};
    tbl[7] = '{1, 0, 3,  44,  0, 3};
    tbl[8] = '{1, 0, 1,  64,  0, 1};
    tbl[9] = '{1, 3, 2,  30,  7, 1};

    #1;
    chk("init.row_bin",   32'(row_bin),   0);
    chk("init.row_oh",    32'(row_oh),    1);
    chk("init.col",       32'(col),       0);
    chk("init.frame_idx", 32'(frame_idx), 0);
    chk("init.scan_done", 32'(scan_done), 0);
    @(negedge clk);
    en = 1'b1; mode = 2'd1; frame_sel = 2'd0;
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      en = tbl[i].en; mode = 2'(tbl[i].mode); frame_sel = 2'(tbl[i].sel);
      repeat (tbl[i].cycles) step("tbl");
      chk($sformatf("tbl%0d.row_bin", i),   32'(row_bin),   tbl[i].exp_row);
      chk($sformatf("tbl%0d.frame_idx", i), 32'(frame_idx), tbl[i].exp_frame);
    end

    // Static frame change requested mid-scan, plus scan period.
    do_reset(1'b1, 0, 0);
    repeat (20) step("stat");
    chk("stat.row5", 32'(row_bin), 5);
    frame_sel = 2'd2;
    repeat (43) step("stat");
    chk("stat.row15",     32'(row_bin),   15);
    chk("stat.col_old",   32'(col),       32'h8000);
    chk("stat.frame_old", 32'(frame_idx), 0);
    step("stat");
    chk("stat.row0",      32'(row_bin),   0);
    chk("stat.done",      32'(scan_done), 1);
    chk("stat.col_new",   32'(col),       32'hFFFF);
    chk("stat.frame_new", 32'(frame_idx), 2);
    repeat (3) step("stat");
    chk("stat.row_hold", 32'(row_bin), 0);
    step("stat");
    chk("stat.row_step", 32'(row_bin), 1);
    wait_done("period1", 100, cyc);
    chk("period1.cycles", cyc, 60);
    wait_done("period2", 100, cyc);
    chk("period2.cycles", cyc, 64);

    // Blink: two lit scans, two dark scans, lit again.
    do_reset(1'b1, 2, 1);
    for (int s = 1; s <= 4; s++) begin
      wait_done($sformatf("blink%0d", s), 100, cyc);
      chk($sformatf("blink%0d.col", s), 32'(col), (s == 1 || s == 4) ? 32'h5555 : 32'h0);
    end

    // Enable dropped at row 7.
    do_reset(1'b1, 0, 0);
    repeat (29) step("en");
    chk("en.row7", 32'(row_bin), 7);
    en = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step("en_off");
      chk("en_off.row",  32'(row_bin),   7);
      chk("en_off.col",  32'(col),       0);
      chk("en_off.done", 32'(scan_done), 0);
    end
    en = 1'b1;
    repeat (2) step("en_on");
    chk("en_on.row7", 32'(row_bin), 7);
    step("en_on");
    chk("en_on.row8", 32'(row_bin), 8);

    // Reset mid-scan in animation at frame 3, row 9.
    do_reset(1'b1, 1, 0);
    repeat (420) step("anim");
    chk("anim.row9",   32'(row_bin),   9);
    chk("anim.frame3", 32'(frame_idx), 3);
    do_reset(1'b1, 1, 0);
    cyc = 0;
    do begin
      step("post_rst");
      cyc++;
      if (cyc == 1) chk("post_rst.col", 32'(col), 32'h0001);
    end while (row_bin != 4'd1 && cyc < 20);
    chk("post_rst.first_tick", cyc, SD);

    // Random traffic against the reference.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 49) == 0) frame_sel = 2'($urandom_range(0, 3));
      if (en ? ($urandom_range(0, 59) == 0) : ($urandom_range(0, 3) == 0)) en = ~en;
      if ($urandom_range(0, 799) == 0) do_reset(en, int'(mode), int'(frame_sel));
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
